phy_clk_ctrl: RTL and testbench

- Single-domain clock-enable controller for the PHY datapath, running on clk_32f.
- Produces registered divided-clock phases (clk_4f, clk_2f, clk_f) and one-cycle period-end strobes for the f/2f/4f datapath stages.
- Sequences start-up, lock indication, resynchronisation and graceful stop, so downstream serializer/deserializer stages start and stop only on clk_f frame boundaries.

---
 rtl/phy_clk_ctrl.sv | 130 +++++++++++++
 tb/tb_phy_clk_ctrl.sv | 147 ++++++++++++++
 2 files changed

// File: rtl/phy_clk_ctrl.sv
// phy_clk_ctrl -- clock-enable controller for the PHY datapath (clk_32f domain).
//
// Derives registered divided phases (clk_4f/clk_2f/clk_f) from a 5-bit phase
// counter, plus one-cycle period-end strobes. It sequences start-up (SETTLE),
// lock indication (LOCKED) and a graceful stop (DRAIN), so downstream SerDes
// stages start and stop only on clk_f frame boundaries.
//
// Ports:
//   clk_32f  in   sole clock, rising edge
//   reset    in   synchronous, active-low
//   enable   in   level: run request; low stops at the next frame boundary
//   resync   in   pulse: realign phase to 0 and restart settling
//   clk_4f   out  phase, period 8   (cnt[2])
//   clk_2f   out  phase, period 16  (cnt[3])
//   clk_f    out  phase, period 32  (cnt[4])
//   stb_4f   out  last cycle of each clk_4f period
//   stb_2f   out  last cycle of each clk_2f period
//   stb_f    out  last cycle of each clk_f period (frame boundary)
//   locked   out  phases stable and usable by the datapath
//   running  out  high in SETTLE, LOCKED and DRAIN
module phy_clk_ctrl #(
    parameter int unsigned SETTLE_PERIODS = 2  // legal 1..15
) (
    input  logic clk_32f,
    input  logic reset,
    input  logic enable,
    input  logic resync,
    output logic clk_4f,
    output logic clk_2f,
    output logic clk_f,
    output logic stb_4f,
    output logic stb_2f,
    output logic stb_f,
    output logic locked,
    output logic running
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_LOCKED = 2'd2,
        ST_DRAIN  = 2'd3
    } state_e;

    localparam logic [3:0] SETTLE_TGT = 4'(SETTLE_PERIODS);

    state_e     state_q, state_d;
    logic [4:0] cnt_q, cnt_d;
    logic [3:0] settle_q, settle_d;
    logic       locked_q, locked_d;
    logic       running_d;
    logic [5:0] out_q, out_d;  // {clk_f, clk_2f, clk_4f, stb_f, stb_2f, stb_4f}
    logic       wrap;

    assign wrap = (cnt_q == 5'd31);

    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        // Counter runs in every non-IDLE state; IDLE holds it at 0.
        cnt_d    = (state_q == ST_IDLE) ? 5'd0 : cnt_q + 5'd1;

        unique case (state_q)
            ST_IDLE: begin
                settle_d = 4'd0;
                if (enable) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                // enable beats resync, resync beats the settle wrap.
                if (!enable) begin
                    state_d = ST_DRAIN;
                end else if (resync) begin
                    cnt_d    = 5'd0;
                    settle_d = 4'd0;
                end else if (wrap) begin
                    settle_d = settle_q + 4'd1;
                    if (settle_d == SETTLE_TGT) state_d = ST_LOCKED;
                end
            end
            ST_LOCKED: begin
                if (!enable) begin
                    state_d = ST_DRAIN;
                end else if (resync) begin
                    state_d  = ST_SETTLE;
                    cnt_d    = 5'd0;
                    settle_d = 4'd0;
                end
            end
            ST_DRAIN: begin
                // Re-enable resumes without touching the phase. A drain that
                // started from SETTLE was never locked, so it resumes settling.
                if (enable)    state_d = locked_q ? ST_LOCKED : ST_SETTLE;
                else if (wrap) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        running_d = (state_d != ST_IDLE);
        locked_d  = (state_d == ST_LOCKED) || ((state_d == ST_DRAIN) && locked_q);

        // Outputs are registered from the next counter value so they line up
        // with cnt_q in the same cycle.
        out_d = {cnt_d[4], cnt_d[3], cnt_d[2],
                 running_d && (cnt_d == 5'd31),
                 running_d && (cnt_d[3:0] == 4'hF),
                 running_d && (cnt_d[2:0] == 3'h7)};
    end

    always_ff @(posedge clk_32f) begin
        if (!reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= 5'd0;
            settle_q <= 4'd0;
            locked_q <= 1'b0;
            running  <= 1'b0;
            out_q    <= 6'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            settle_q <= settle_d;
            locked_q <= locked_d;
            running  <= running_d;
            out_q    <= out_d;
        end
    end

    assign {clk_f, clk_2f, clk_4f, stb_f, stb_2f, stb_4f} = out_q;
    assign locked = locked_q;

endmodule

// File: tb/tb_phy_clk_ctrl.sv
// Directed bench for phy_clk_ctrl (SETTLE_PERIODS=2). Outputs are sampled 1
// time unit after each rising edge; inputs are changed at that same point so
// the DUT sees them at the following edge.
module tb_phy_clk_ctrl;

    logic clk_32f = 1'b0;
    logic reset   = 1'b0;
    logic enable  = 1'b1;
    logic resync  = 1'b0;
    logic clk_4f, clk_2f, clk_f, stb_4f, stb_2f, stb_f, locked, running;

    int n_cmp = 0;
    int n_err = 0;

    phy_clk_ctrl #(.SETTLE_PERIODS(2)) dut (
        .clk_32f (clk_32f),
        .reset   (reset),
        .enable  (enable),
        .resync  (resync),
        .clk_4f  (clk_4f),
        .clk_2f  (clk_2f),
        .clk_f   (clk_f),
        .stb_4f  (stb_4f),
        .stb_2f  (stb_2f),
        .stb_f   (stb_f),
        .locked  (locked),
        .running (running)
    );

    always #5 clk_32f = ~clk_32f;

    logic [7:0] obs;
    assign obs = {clk_f, clk_2f, clk_4f, stb_f, stb_2f, stb_4f, locked, running};

    // Expected output vector for a given phase count and lock/run flags,
    // straight from the output definitions.
    function automatic logic [7:0] ev(input int c, input bit lk, input bit run);
        logic [4:0] k;
        k = c[4:0];
        return {k[4], k[3], k[2],
                run && (k == 5'd31),
                run && (k[3:0] == 4'hF),
                run && (k[2:0] == 3'h7),
                lk, run};
    endfunction

    task automatic adv(input int n);
        repeat (n) @(posedge clk_32f);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $display("FAIL %s: got %b want %b (f,2f,4f,sf,s2,s4,lk,run)", tag, obs, exp);
            $error("%s observed %b expected %b", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset held with enable high.
        adv(5);
        chk("reset_hold", 8'h00);
        reset = 1'b1;
        adv(1);  chk("settle_entry", ev(0, 0, 1));
        adv(7);  chk("first_stb4f", ev(7, 0, 1));
        adv(1);  chk("clk4f_high", ev(8, 0, 1));
        adv(23); chk("first_stbf", ev(31, 0, 1));
        adv(1);  chk("wrap1_unlocked", ev(0, 0, 1));
        adv(31); chk("pre_lock", ev(31, 0, 1));
        adv(1);  chk("lock_at_64", ev(0, 1, 1));
        adv(16); chk("clkf_high", ev(16, 1, 1));

        // Drop enable at cnt 5: drain to the frame boundary then IDLE.
        adv(21); chk("locked_cnt5", ev(5, 1, 1));
        enable = 1'b0;
        adv(1);  chk("drain_cnt6", ev(6, 1, 1));
        adv(25); chk("drain_stbf", ev(31, 1, 1));
        adv(1);  chk("idle_after_drain", 8'h00);
        adv(3);  chk("idle_stays", 8'h00);

        // Resync is ignored in IDLE.
        resync = 1'b1;
        adv(1);  chk("idle_resync_ign", 8'h00);
        resync = 1'b0;

        // Drop enable exactly at cnt 31: full 32-cycle drain.
        enable = 1'b1;
        adv(1);  chk("settle2_entry", ev(0, 0, 1));
        adv(64); chk("lock2", ev(0, 1, 1));
        adv(31); chk("lock2_cnt31", ev(31, 1, 1));
        enable = 1'b0;
        adv(1);  chk("drain_full_start", ev(0, 1, 1));
        adv(31); chk("drain_full_end", ev(31, 1, 1));
        adv(1);  chk("idle_after_full", 8'h00);

        // Resync in LOCKED at cnt 12.
        enable = 1'b1;
        adv(1);  chk("settle3_entry", ev(0, 0, 1));
        adv(64); chk("lock3", ev(0, 1, 1));
        adv(12); chk("locked_cnt12", ev(12, 1, 1));
        resync = 1'b1;
        adv(1);  chk("resync_realign", ev(0, 0, 1));
        resync = 1'b0;
        adv(63); chk("resync_prelock", ev(31, 0, 1));
        adv(1);  chk("resync_relock", ev(0, 1, 1));

        // Re-enable during DRAIN at cnt 20: stays locked, no phase gap.
        adv(10); chk("locked_cnt10", ev(10, 1, 1));
        enable = 1'b0;
        adv(1);  chk("drain_cnt11", ev(11, 1, 1));
        adv(9);  chk("drain_cnt20", ev(20, 1, 1));
        enable = 1'b1;
        adv(1);  chk("relock_cnt21", ev(21, 1, 1));
        adv(10); chk("relock_cnt31", ev(31, 1, 1));
        adv(1);  chk("relock_no_idle", ev(0, 1, 1));

        // One-cycle reset mid-LOCKED at cnt 17.
        adv(17); chk("locked_cnt17", ev(17, 1, 1));
        reset = 1'b0;
        adv(1);  chk("midframe_reset", 8'h00);
        reset = 1'b1;
        adv(1);  chk("post_reset_settle", ev(0, 0, 1));

        // Resync on the locking settle wrap: resync wins, settling restarts.
        adv(63); chk("settle_last_wrap", ev(31, 0, 1));
        resync = 1'b1;
        adv(1);  chk("resync_beats_lock", ev(0, 0, 1));
        resync = 1'b0;
        adv(63); chk("restart_prelock", ev(31, 0, 1));
        adv(1);  chk("restart_lock", ev(0, 1, 1));

        // Resync and enable fall together: DRAIN without realign.
        adv(3);  chk("locked_cnt3", ev(3, 1, 1));
        enable = 1'b0;
        resync = 1'b1;
        adv(1);  chk("enable_beats_resync", ev(4, 1, 1));
        resync = 1'b0;
        adv(27); chk("drain4_stbf", ev(31, 1, 1));
        adv(1);  chk("idle_final", 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
